// File: rtl/branch_unit_bht.sv
// RV32 conditional-branch resolver with a PC-indexed table of 2-bit saturating
// direction counters and saturating branch / mispredict performance counters.
module branch_unit_bht #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter int         PC_LSB      = 2,
  parameter logic [1:0] CNT_INIT    = 2'b01,
  parameter int         STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic              ex_pred_taken,
  output logic              ex_taken,
  output logic              ex_mispredict,
  output logic              ex_illegal,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [1:0]        bht_upd_d;
  logic [STAT_W-1:0] br_q, br_d, mp_q, mp_d;
  logic [IDX_W-1:0]  if_idx, ex_idx;
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic eq, lt, ltu, cond, legal, resolve;
  logic unused_pc_bits;

  // Bits outside the index window are intentionally ignored (aliasing by design).
  assign unused_pc_bits = ^{if_pc, ex_pc};
  assign if_idx = if_pc[PC_LSB +: IDX_W];
  assign ex_idx = ex_pc[PC_LSB +: IDX_W];

  assign rs1_s = ex_rs1;
  assign rs2_s = ex_rs2;
  assign eq    = (ex_rs1 == ex_rs2);
  assign lt    = (rs1_s < rs2_s);
  assign ltu   = (ex_rs1 < ex_rs2);

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (ex_funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      3'b110:  cond = ltu;
      3'b111:  cond = !ltu;
      default: legal = 1'b0;
    endcase
  end

  assign resolve       = ex_valid & ex_branch & legal;
  assign ex_taken      = resolve & cond;
  assign ex_mispredict = resolve & (ex_taken ^ ex_pred_taken);
  assign ex_illegal    = ex_valid & ex_branch & !legal;

  // Read is the registered value, so a same-cycle train on this entry is not bypassed.
  assign if_pred_taken = bht_q[if_idx][1];
  assign bht_upd_d     = sat_step(bht_q[ex_idx], ex_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_INIT;
    end else if (resolve) begin
      bht_q[ex_idx] <= bht_upd_d;
    end
  end

  assign br_d = resolve       ? sat_inc(br_q) : br_q;
  assign mp_d = ex_mispredict ? sat_inc(mp_q) : mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign stat_branches = br_q;
  assign stat_mispred  = mp_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Scoreboard bench for branch_unit_bht: stimulus pushes expected values,
// a monitor pops and compares them at the falling edge.
module tb_branch_unit_bht;

  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken, if_pred4;
  logic        ex_valid, ex_branch, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_rs1, ex_rs2;
  logic        ex_taken, ex_mispredict, ex_illegal;
  logic        ex_taken4, ex_mispredict4, ex_illegal4;
  logic [31:0] stat_branches, stat_mispred;
  logic [3:0]  stat_branches4, stat_mispred4;

  always #5 clk = ~clk;

  branch_unit_bht u_dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .ex_mispredict(ex_mispredict), .ex_illegal(ex_illegal),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  branch_unit_bht #(.STAT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred4),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken4), .ex_mispredict(ex_mispredict4), .ex_illegal(ex_illegal4),
    .stat_branches(stat_branches4), .stat_mispred(stat_mispred4)
  );

  typedef struct { string name; int sel; logic [31:0] exp; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0: return {31'd0, if_pred_taken};
      1: return {31'd0, ex_taken};
      2: return {31'd0, ex_mispredict};
      3: return {31'd0, ex_illegal};
      4: return stat_branches;
      5: return stat_mispred;
      6: return {28'd0, stat_branches4};
      7: return {28'd0, stat_mispred4};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: every falling edge, drain expectations queued during this cycle.
  initial begin
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        a = actual(e.sel);
        n_cmp++;
        if (a !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string n, input int sel, input logic [31:0] e);
    sb.push_back('{n, sel, e});
  endtask

  task automatic drive(input logic v, input logic b, input logic [2:0] f, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] bb, input logic p);
    ex_valid = v; ex_branch = b; ex_funct3 = f; ex_pc = pc;
    ex_rs1 = a; ex_rs2 = bb; ex_pred_taken = p;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, BEQ, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    tick(); idle(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
  endtask

  typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic p; logic t; logic m; } cvec_t;
  cvec_t cv[10];
  logic [31:0] pcs[4];

  initial begin
    cv = '{
      '{3'b100, 32'hFFFF_FFFB, 32'h0000_000A, 1'b0, 1'b1, 1'b1},
      '{3'b101, 32'hFFFF_FFFB, 32'h0000_000A, 1'b0, 1'b0, 1'b0},
      '{3'b110, 32'hFFFF_FFFB, 32'h0000_000A, 1'b0, 1'b0, 1'b0},
      '{3'b111, 32'hFFFF_FFFB, 32'h0000_000A, 1'b0, 1'b1, 1'b1},
      '{3'b000, 32'hFFFF_FFFB, 32'h0000_000A, 1'b0, 1'b0, 1'b0},
      '{3'b001, 32'hFFFF_FFFB, 32'h0000_000A, 1'b0, 1'b1, 1'b1},
      '{3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1},
      '{3'b100, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0},
      '{3'b111, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1},
      '{3'b100, 32'hFFFF_FFFB, 32'h0000_000A, 1'b1, 1'b1, 1'b0}
    };
    pcs = '{32'h0, 32'h4, 32'h100, 32'hFC};

    rst_n = 1'b1; if_pc = 32'h0; idle();
    #2 rst_n = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) begin
      tick(); if_pc = pcs[i];
      expect_v("reset_pred", 0, 32'd0);
      expect_v("reset_br", 4, 32'd0);
      expect_v("reset_mp", 5, 32'd0);
    end
    tick(); rst_n = 1'b1;

    // Compare table (ex_pc 0x3C, index 15, away from later entries)
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(1'b1, 1'b1, cv[i].f3, 32'h3C, cv[i].a, cv[i].b, cv[i].p);
      expect_v($sformatf("cmp%0d_taken", i), 1, {31'd0, cv[i].t});
      expect_v($sformatf("cmp%0d_misp", i), 2, {31'd0, cv[i].m});
      expect_v($sformatf("cmp%0d_ill", i), 3, 32'd0);
    end

    // Training on 0x100 (index 0): 01 -> 10 -> 11 -> 11 -> 11
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1'b1, 1'b1, BEQ, 32'h100, 32'h0, 32'h0, 1'b0); if_pc = 32'h100;
      expect_v($sformatf("train_up%0d", i), 0, (i == 0) ? 32'd0 : 32'd1);
    end
    tick(); idle(); if_pc = 32'h104;
    expect_v("neighbour_0x104", 0, 32'd0);
    // 11 -> 10 -> 01 -> 00
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b1, 1'b1, BNE, 32'h100, 32'h0, 32'h0, 1'b1); if_pc = 32'h100;
      expect_v($sformatf("train_dn%0d", i), 0, (i < 2) ? 32'd1 : 32'd0);
    end
    tick(); idle(); if_pc = 32'h100;
    expect_v("train_floor", 0, 32'd0);

    // Collision on 0x200 (shares index 0, now 00): bring to 01, then collide
    tick(); drive(1'b1, 1'b1, BEQ, 32'h200, 32'h0, 32'h0, 1'b0); if_pc = 32'h200;
    expect_v("coll_setup", 0, 32'd0);
    tick(); expect_v("coll_same_cycle", 0, 32'd0);
    tick(); idle(); expect_v("coll_next_cycle", 0, 32'd1);

    // Gating: all conditions otherwise true, prediction 1
    do_reset();
    if_pc = 32'h40;
    tick(); drive(1'b0, 1'b1, BEQ, 32'h40, 32'h5, 32'h5, 1'b1);
    expect_v("gate_bubble_taken", 1, 32'd0); expect_v("gate_bubble_misp", 2, 32'd0);
    tick(); drive(1'b1, 1'b0, BEQ, 32'h40, 32'h5, 32'h5, 1'b1);
    expect_v("gate_nonbr_taken", 1, 32'd0); expect_v("gate_nonbr_misp", 2, 32'd0);
    expect_v("gate_nonbr_ill", 3, 32'd0);
    tick(); drive(1'b1, 1'b1, 3'b010, 32'h40, 32'h5, 32'h5, 1'b1);
    expect_v("gate_f010_taken", 1, 32'd0); expect_v("gate_f010_misp", 2, 32'd0);
    expect_v("gate_f010_ill", 3, 32'd1);
    tick(); drive(1'b1, 1'b1, 3'b011, 32'h40, 32'h5, 32'h5, 1'b1);
    expect_v("gate_f011_ill", 3, 32'd1);
    tick(); drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h5, 32'h5, 1'b1);
    expect_v("gate_bubble_ill", 3, 32'd0);
    tick(); idle();
    expect_v("gate_table", 0, 32'd0);
    expect_v("gate_br", 4, 32'd0);
    expect_v("gate_mp", 5, 32'd0);

    // Stats: 10 resolves, 3 mispredicts (all taken; pred 0 on last three)
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(); drive(1'b1, 1'b1, BEQ, 32'h80, 32'h7, 32'h7, (i < 7) ? 1'b1 : 1'b0);
    end
    tick(); idle();
    expect_v("stat10_br", 4, 32'd10); expect_v("stat10_mp", 5, 32'd3);
    expect_v("stat10_br4", 6, 32'd10); expect_v("stat10_mp4", 7, 32'd3);
    for (int i = 0; i < 10; i++) begin
      tick(); drive(1'b1, 1'b1, BEQ, 32'h80, 32'h7, 32'h7, 1'b0);
    end
    tick(); idle();
    expect_v("stat20_br", 4, 32'd20); expect_v("stat20_mp", 5, 32'd13);
    expect_v("stat20_br4_sat", 6, 32'hF); expect_v("stat20_mp4", 7, 32'd13);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b1, 1'b1, BEQ, 32'h80, 32'h7, 32'h7, 1'b0);
    end
    tick(); idle();
    expect_v("stat23_br", 4, 32'd23); expect_v("stat23_mp", 5, 32'd16);
    expect_v("stat23_br4_sat", 6, 32'hF); expect_v("stat23_mp4_sat", 7, 32'hF);

    // Asynchronous reset between edges, with a resolve in flight
    tick(); drive(1'b1, 1'b1, BEQ, 32'h80, 32'h7, 32'h7, 1'b0); if_pc = 32'h80;
    #2 rst_n = 1'b0;
    expect_v("arst_pred", 0, 32'd0);
    expect_v("arst_br", 4, 32'd0); expect_v("arst_mp", 5, 32'd0);
    expect_v("arst_br4", 6, 32'd0); expect_v("arst_mp4", 7, 32'd0);
    expect_v("arst_taken_comb", 1, 32'd1); expect_v("arst_misp_comb", 2, 32'd1);
    tick(); expect_v("arst_hold_br", 4, 32'd0); expect_v("arst_hold_pred", 0, 32'd0);
    tick(); rst_n = 1'b1;
    tick(); idle();
    expect_v("post_rst_br", 4, 32'd1); expect_v("post_rst_mp", 5, 32'd1);
    expect_v("post_rst_pred", 0, 32'd1);

    tick();
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
